// File: rtl/window_frame_ctrl.sv
// Frame controller joining a PDM sample stream with a window generator.
// Aligns to the window period, emits fixed-length frames, then idles a gap.
module window_frame_ctrl #(
  parameter int unsigned WIDTH_POW2 = 10,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        sample_in_valid,
  output logic        sample_in_ready,
  input  logic        win_valid,
  input  logic        win_last,
  output logic        win_ready,
  output logic        pair_valid,
  output logic        pair_last,
  input  logic        pair_ready,
  output logic [15:0] frame_count,
  output logic        busy,
  output logic        err_misalign
);

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    RUN,
    GAP
  } state_t;

  localparam int unsigned GW =
    (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t                state;
  state_t                state_nxt;
  logic [WIDTH_POW2-1:0] beat;
  logic [WIDTH_POW2-1:0] beat_nxt;
  logic [GW-1:0]         gap_cnt;
  logic [GW-1:0]         gap_nxt;
  logic                  aligned;
  logic                  aligned_nxt;
  logic                  err_set;
  logic                  frame_inc;
  logic                  xfer;
  logic                  is_last;

  assign is_last = (beat == '1);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      beat         <= '0;
      gap_cnt      <= '0;
      aligned      <= 1'b0;
      frame_count  <= '0;
      err_misalign <= 1'b0;
    end else begin
      state   <= state_nxt;
      beat    <= beat_nxt;
      gap_cnt <= gap_nxt;
      aligned <= aligned_nxt;
      if (frame_inc)
        frame_count <= frame_count + 16'd1;
      if (err_set)
        err_misalign <= 1'b1;
    end
  end

  always_comb begin
    state_nxt       = state;
    beat_nxt        = beat;
    gap_nxt         = gap_cnt;
    aligned_nxt     = aligned;
    err_set         = 1'b0;
    frame_inc       = 1'b0;
    xfer            = 1'b0;
    sample_in_ready = 1'b0;
    win_ready       = 1'b0;
    pair_valid      = 1'b0;
    pair_last       = 1'b0;
    unique case (state)
      IDLE: begin
        beat_nxt = '0;
        if (enable)
          state_nxt = aligned ? RUN : ALIGN;
      end
      ALIGN: begin
        win_ready = 1'b1;
        beat_nxt  = '0;
        if (win_valid && win_last) begin
          state_nxt   = RUN;
          aligned_nxt = 1'b1;
        end
      end
      RUN: begin
        pair_valid      = sample_in_valid & win_valid;
        sample_in_ready = win_valid & pair_ready;
        win_ready       = sample_in_valid & pair_ready;
        pair_last       = pair_valid & is_last;
        xfer            = pair_valid & pair_ready;
        if (xfer) begin
          beat_nxt = beat + 1'b1;
          // period end must coincide with frame end
          if (win_last != is_last) begin
            err_set     = 1'b1;
            aligned_nxt = 1'b0;
          end
          if (is_last) begin
            frame_inc = 1'b1;
            if (!win_last)
              state_nxt = enable ? ALIGN : IDLE;
            else if (GAP_CYCLES > 0) begin
              state_nxt = GAP;
              gap_nxt   = '0;
            end else
              state_nxt = enable ? RUN : IDLE;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          gap_nxt   = '0;
          state_nxt = enable ? RUN : IDLE;
        end else
          gap_nxt = gap_cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_window_frame_ctrl.sv
// Directed bench for window_frame_ctrl with a triangle window model.
// WIDTH_POW2=4 (16-beat frames), GAP_CYCLES=2.
module tb_window_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        sample_in_valid = 1'b0;
  logic        win_valid = 1'b0;
  logic        pair_ready = 1'b0;
  logic        win_last;
  logic        sample_in_ready;
  logic        win_ready;
  logic        pair_valid;
  logic        pair_last;
  logic [15:0] frame_count;
  logic        busy;
  logic        err_misalign;

  logic        extra = 1'b0;
  logic [4:0]  widx = '0;
  int          wcons = 0;
  int          scons = 0;
  int          xw[$];
  bit          xl[$];
  bit          xwl[$];
  int          checks = 0;
  int          errors = 0;

  window_frame_ctrl #(
    .WIDTH_POW2(4),
    .GAP_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .sample_in_valid(sample_in_valid),
    .sample_in_ready(sample_in_ready),
    .win_valid(win_valid),
    .win_last(win_last),
    .win_ready(win_ready),
    .pair_valid(pair_valid),
    .pair_last(pair_last),
    .pair_ready(pair_ready),
    .frame_count(frame_count),
    .busy(busy),
    .err_misalign(err_misalign)
  );

  always #5 clk = ~clk;

  function automatic int tri_val(int i);
    return (i < 8) ? (7 - i) : (i - 7);
  endfunction

  // extra mode: a value of 15 is inserted at position 8 (17-long period)
  function automatic int win_val(int i, logic ex);
    if (!ex || i < 8) return tri_val(i);
    if (i == 8) return 15;
    return tri_val(i - 1);
  endfunction

  assign win_last = (widx == (extra ? 5'd16 : 5'd15));

  always @(posedge clk) begin
    if (rst) begin
      if (win_valid && win_ready) begin
        wcons <= wcons + 1;
        widx  <= win_last ? 5'd0 : widx + 5'd1;
      end
      if (sample_in_valid && sample_in_ready)
        scons <= scons + 1;
      if (pair_valid && pair_ready) begin
        xw.push_back(win_val(int'(widx), extra));
        xl.push_back(pair_last);
        xwl.push_back(win_last);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; enable = 1'b1;
    sample_in_valid = 1'b1; win_valid = 1'b1; pair_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({sample_in_ready, win_ready, pair_valid, pair_last} !== 4'b0) begin
      errors++;
      $display("FAIL reset_outs: got %b expected 0000",
        {sample_in_ready, win_ready, pair_valid, pair_last});
    end
    checks++;
    if (busy !== 1'b0 || err_misalign !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b err=%b expected 0 0", busy, err_misalign);
    end
    checks++;
    if (frame_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d expected 0", frame_count);
    end
    tick();
    enable = 1'b0;
    sample_in_valid = 1'b0; win_valid = 1'b0; pair_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_first_frame();
    int w0 = wcons;
    int x0 = xw.size();
    int x1;
    bit ok = 1'b0;
    enable = 1'b1;
    sample_in_valid = 1'b1; win_valid = 1'b1; pair_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (pair_valid) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || wcons - w0 !== 16) begin
      errors++;
      $display("FAIL align_consume: got %0d values (seen=%b) expected 16", wcons - w0, ok);
    end
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (frame_count == 16'd1) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || xw.size() - x0 !== 16) begin
      errors++;
      $display("FAIL frame1_len: got %0d beats expected 16", xw.size() - x0);
    end
    if (xw.size() - x0 >= 16)
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (xw[x0+i] !== tri_val(i) || xl[x0+i] !== (i == 15)) begin
          errors++;
          $display("FAIL frame1_beat%0d: got win=%0d last=%b expected win=%0d last=%b",
            i, xw[x0+i], xl[x0+i], tri_val(i), (i == 15));
        end
      end
    checks++;
    if ({sample_in_ready, win_ready, pair_valid, busy} !== 4'b0001) begin
      errors++;
      $display("FAIL gap1: got %b expected 0001",
        {sample_in_ready, win_ready, pair_valid, busy});
    end
    tick();
    sample_in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({sample_in_ready, win_ready, pair_valid, busy} !== 4'b0001) begin
      errors++;
      $display("FAIL gap2: got %b expected 0001",
        {sample_in_ready, win_ready, pair_valid, busy});
    end
    @(negedge clk);
    checks++;
    if ({sample_in_ready, win_ready, pair_valid, busy} !== 4'b1001) begin
      errors++;
      $display("FAIL run_no_sample: got %b expected 1001",
        {sample_in_ready, win_ready, pair_valid, busy});
    end
    x1 = xw.size();
    w0 = wcons;
    repeat (3) @(negedge clk);
    checks++;
    if (xw.size() !== x1 || wcons !== w0) begin
      errors++;
      $display("FAIL run_hold: got %0d xfers %0d wins expected 0 0",
        xw.size() - x1, wcons - w0);
    end
  endtask

  task automatic test_stalls();
    int x0 = xw.size();
    int w0 = wcons;
    int s0 = scons;
    bit ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      tick();
      if (xw.size() - x0 >= 48) begin ok = 1'b1; break; end
      sample_in_valid = ($urandom_range(0, 3) != 0);
      win_valid       = ($urandom_range(0, 3) != 0);
      pair_ready      = ($urandom_range(0, 3) != 0);
    end
    sample_in_valid = 1'b0; win_valid = 1'b0; pair_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (!ok || scons - s0 !== 48 || wcons - w0 !== 48) begin
      errors++;
      $display("FAIL stall_counts: got xfer=%0d smp=%0d win=%0d expected 48",
        xw.size() - x0, scons - s0, wcons - w0);
    end
    if (ok)
      for (int i = 0; i < 48; i++) begin
        checks++;
        if (xw[x0+i] !== tri_val(i % 16) || xl[x0+i] !== (i % 16 == 15)) begin
          errors++;
          $display("FAIL stall_beat%0d: got win=%0d last=%b expected win=%0d last=%b",
            i, xw[x0+i], xl[x0+i], tri_val(i % 16), (i % 16 == 15));
        end
      end
    checks++;
    if (frame_count !== 16'd4 || err_misalign !== 1'b0) begin
      errors++;
      $display("FAIL stall_frames: got count=%0d err=%b expected 4 0",
        frame_count, err_misalign);
    end
    repeat (4) tick();
    win_valid = 1'b1; pair_ready = 1'b1;
  endtask

  task automatic test_enable_drop();
    int x0 = xw.size();
    int w1;
    bit ok = 1'b0;
    sample_in_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (xw.size() - x0 == 5) enable = 1'b0;
      if (frame_count == 16'd5) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || xw.size() - x0 !== 16 || xl[$] !== 1'b1) begin
      errors++;
      $display("FAIL drop_frame: got %0d beats expected 16 ending in last", xw.size() - x0);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL drop_gap: got busy=%b expected 1", busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || pair_valid !== 1'b0 || sample_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL drop_idle: got busy=%b pv=%b sr=%b expected 0 0 0",
        busy, pair_valid, sample_in_ready);
    end
    tick();
    enable = 1'b1;
    w1 = wcons;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (pair_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reenable_run: got pv=%b busy=%b expected 1 1", pair_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (xw[$] !== 7 || wcons - w1 !== 1) begin
      errors++;
      $display("FAIL reenable_first: got win=%0d consumed=%0d expected 7 1",
        xw[$], wcons - w1);
    end
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (frame_count == 16'd6) begin ok = 1'b1; break; end
    end
    sample_in_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL reenable_frame: got count=%0d expected 6", frame_count);
    end
    repeat (4) tick();
  endtask

  task automatic test_misalign();
    int w1;
    bit ok = 1'b0;
    checks++;
    if (err_misalign !== 1'b0) begin
      errors++;
      $display("FAIL pre_misalign: got err=%b expected 0", err_misalign);
    end
    extra = 1'b1;
    sample_in_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (frame_count == 16'd7) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || err_misalign !== 1'b1) begin
      errors++;
      $display("FAIL misalign_err: got count=%0d err=%b expected 7 1",
        frame_count, err_misalign);
    end
    checks++;
    if ({busy, win_ready, pair_valid, sample_in_ready} !== 4'b1100) begin
      errors++;
      $display("FAIL misalign_align: got %b expected 1100",
        {busy, win_ready, pair_valid, sample_in_ready});
    end
    w1 = wcons;
    @(negedge clk);
    checks++;
    if (pair_valid !== 1'b1 || wcons - w1 !== 1) begin
      errors++;
      $display("FAIL relock: got pv=%b consumed=%0d expected 1 1", pair_valid, wcons - w1);
    end
    tick();
    extra = 1'b0;
    checks++;
    if (xw[$] !== 7) begin
      errors++;
      $display("FAIL relock_first: got win=%0d expected 7", xw[$]);
    end
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (frame_count == 16'd8) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || err_misalign !== 1'b1 || xl[$] !== 1'b1 || xwl[$] !== 1'b1) begin
      errors++;
      $display("FAIL relock_frame: got count=%0d err=%b last=%b wlast=%b expected 8 1 1 1",
        frame_count, err_misalign, xl[$], xwl[$]);
    end
    tick();
    sample_in_valid = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    int x0 = xw.size();
    int w1;
    bit ok = 1'b0;
    sample_in_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (xw.size() - x0 == 9) begin ok = 1'b1; break; end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (!ok || {pair_valid, sample_in_ready, win_ready, busy, err_misalign} !== 5'b0) begin
      errors++;
      $display("FAIL midreset_outs: got %b expected 00000",
        {pair_valid, sample_in_ready, win_ready, busy, err_misalign});
    end
    checks++;
    if (frame_count !== 16'd0) begin
      errors++;
      $display("FAIL midreset_count: got %0d expected 0", frame_count);
    end
    tick();
    rst = 1'b1;
    w1 = wcons;
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (pair_valid) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || wcons - w1 !== 7) begin
      errors++;
      $display("FAIL midreset_align: got consumed=%0d expected 7", wcons - w1);
    end
    @(negedge clk);
    checks++;
    if (xw[$] !== 7 || frame_count !== 16'd0) begin
      errors++;
      $display("FAIL midreset_first: got win=%0d count=%0d expected 7 0",
        xw[$], frame_count);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_frame();
    test_stalls();
    test_enable_drop();
    test_misalign();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/window_frame_ctrl.md
WINDOW_FRAME_CTRL -- requirements
Module: window_frame_ctrl

Interface
REQ-001 Parameters SHALL be:
  - WIDTH_POW2, default 10, window generator width; frame length = 2**WIDTH_POW2 beats.
  - GAP_CYCLES, default 16, idle cycles between frames; 0 allowed.
REQ-002 Ports SHALL be:
  - clk  in  1  single clock, all logic rising-edge.
  - rst  in  1  asynchronous, active-low reset.
  - enable  in  1  level; start/continue framing.
  - sample_in_valid  in  1  upstream PDM sample available.
  - sample_in_ready  out  1  upstream sample consumed.
  - win_valid  in  1  window generator value available.
  - win_last  in  1  window generator end-of-period flag.
  - win_ready  out  1  advance window generator.
  - pair_valid  out  1  joined sample+window beat available downstream.
  - pair_last  out  1  final beat of frame.
  - pair_ready  in  1  downstream accepts beat.
  - frame_count  out  16  completed frames, wraps.
  - busy  out  1  state != IDLE.
  - err_misalign  out  1  sticky window/frame misalignment.

Function
REQ-003 FSM SHALL have states IDLE, ALIGN, RUN, GAP; one registered state.
REQ-004 IDLE SHALL drive sample_in_ready, win_ready, pair_valid, pair_last low.
REQ-005 IDLE with enable=1 SHALL go to RUN if aligned=1, else to ALIGN.
REQ-006 ALIGN SHALL drive win_ready=1 and sample_in_ready=0, pair_valid=0.
REQ-007 ALIGN SHALL go to RUN, setting aligned=1, in the cycle after a beat with win_valid & win_last; enable is ignored in ALIGN.
REQ-008 RUN signals SHALL be combinational joins:
  - pair_valid = sample_in_valid & win_valid.
  - sample_in_ready = win_valid & pair_ready.
  - win_ready = sample_in_valid & pair_ready.
REQ-009 A transfer SHALL occur when pair_valid & pair_ready; each transfer consumes exactly one sample and one window value.
REQ-010 The beat counter (WIDTH_POW2 bits) SHALL increment per transfer and return to 0 after beat 2**WIDTH_POW2-1.
REQ-011 pair_last SHALL equal pair_valid & (beat == 2**WIDTH_POW2-1).
REQ-012 On the last-beat transfer with win_last=1, frame_count SHALL increment (wrapping 0xFFFF->0) and the next state SHALL be:
  - GAP if GAP_CYCLES>0;
  - else RUN if enable=1;
  - else IDLE.
REQ-013 On the last-beat transfer with win_last=0, the block SHALL:
  - set err_misalign;
  - clear aligned;
  - still increment frame_count;
  - go to ALIGN if enable=1, else IDLE (GAP skipped).
REQ-014 win_last=1 on a non-last transfer SHALL also set err_misalign and clear aligned, with the frame continuing to its end.
REQ-015 enable deasserted during RUN or GAP SHALL NOT truncate; the current frame and gap complete, then the FSM goes to IDLE.
REQ-016 GAP SHALL hold all readies and pair_valid low for exactly GAP_CYCLES cycles, then go to RUN if enable=1, else IDLE.
REQ-017 busy SHALL be registered-state derived: 1 in ALIGN, RUN, GAP.
REQ-018 err_misalign SHALL remain set until reset.

Reset
REQ-019 rst=0 SHALL asynchronously force:
  - state=IDLE, beat=0, gap counter=0;
  - aligned=0, frame_count=0, err_misalign=0;
  - all outputs 0.
REQ-020 Reset asserted mid-frame SHALL discard the partial frame; after release, a new ALIGN is required.

Verification
REQ-021 WIDTH_POW2=4, GAP_CYCLES=2, triangle model (7..0,1..8, last on 8), enable=1 after reset -> ALIGN consumes 16 values; RUN beats carry windows 7,6..0,1..8; pair_last on beat 16 with win_last=1; frame_count=1; 2 gap cycles with all readies low.
REQ-022 Random pair_ready/sample_in_valid/win_valid stalls over 3 frames -> 48 transfers, no dropped or duplicated sample/window values, frame_count=3, err_misalign=0.
REQ-023 enable dropped at beat 5 -> frame completes all 16 beats plus gap, then IDLE, busy=0; re-enable -> RUN next cycle with no ALIGN, first window 7.
REQ-024 Window model inserts one extra value mid-frame -> err_misalign=1 at frame end, frame_count incremented, FSM enters ALIGN and re-locks on next win_last.
REQ-025 rst=0 at beat 9 of RUN -> outputs 0 immediately (same cycle); frame_count=0; after release with enable=1 -> ALIGN before any pair_valid.
REQ-026 RUN with win_valid=1, sample_in_valid=0 -> pair_valid=0, win_ready=0, beat counter unchanged.
